// File: rtl/bus_dev_pkg.sv
// Shared constants and helpers for the bus device port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_dev_pkg;

  // Width of the destination address carried in each packet's top bits.
  localparam int ADDR_W = 8;

  // Default broadcast destination address.
  localparam logic [ADDR_W-1:0] BCAST = {ADDR_W{1'b1}};

  // Widest packet the destination helper can handle.
  localparam int MAX_PKT_W = 256;

  // Pull the destination field out of a packet that is pkt_w bits wide.
  // Callers zero-extend their packet to MAX_PKT_W bits.
  function automatic logic [ADDR_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                input int unsigned pkt_w);
    return ADDR_W'(pkt >> (pkt_w - ADDR_W));
  endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// First-word-fall-through FIFO with full/empty/count.
// Latency: a write is visible at the head one cycle later; the head is read combinationally.
// Backpressure: reads while empty are ignored; writes while full succeed only alongside a read.
module bus_dev_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr,
  input  logic [width-1:0]         i_wr_dat,
  input  logic                     i_rd,
  output logic [width-1:0]         o_rd_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(depth):0]   o_count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_rd_eff;
  logic w_wr_eff;

  // A read needs data; a write needs room, which a same-cycle read provides.
  assign w_rd_eff = i_rd && !o_empty;
  assign w_wr_eff = i_wr && (!o_full || w_rd_eff);

  assign o_full   = (r_count == CW'(depth));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rd_dat = r_mem[r_rd_ptr];

  // Pointers and occupancy; pointers wrap naturally modulo depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_eff) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_eff) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_eff, w_rd_eff})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (w_wr_eff) r_mem[r_wr_ptr] <= i_wr_dat;
  end

endmodule

// File: rtl/bus_dev_port.sv
// Bus device port: TX FIFO toward the bus, address-filtered RX FIFO from the bus.
// Latency: one cycle from tx_wr/push to pndng/rx_valid; heads are presented combinationally.
// Backpressure: full TX drops tx_wr unless popped; full RX drops matching pushes and sets sticky rx_ovf.
// Optional BUS_DEV_STATS_EN adds saturating tx_cnt/rx_cnt/drop_cnt counters.
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int                pckg_sz   = 16,
  parameter int                depth     = 8,
  parameter logic [ADDR_W-1:0] id        = '0,
  parameter logic [ADDR_W-1:0] broadcast = BCAST
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_rd,
  output logic               rx_ovf
`ifdef BUS_DEV_STATS_EN
  ,
  output logic [15:0]        tx_cnt,
  output logic [15:0]        rx_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int CW = $clog2(depth) + 1;

  logic              w_tx_empty;
  logic              w_rx_empty;
  logic              w_rx_full;
  logic [CW-1:0]     w_tx_count;
  logic [CW-1:0]     w_rx_count;
  logic [ADDR_W-1:0] w_dest;
  logic              w_match;
  logic              w_rx_wr;
  logic              w_rx_ovf_evt;
  logic              r_rx_ovf;

  // Only packets addressed to this device or to everyone enter RX.
  assign w_dest       = dest_of(MAX_PKT_W'(D_push), pckg_sz);
  assign w_match      = (w_dest == id) || (w_dest == broadcast);
  assign w_rx_wr      = push && w_match;
  // Full RX implies non-empty, so a concurrent rx_rd always frees a slot.
  assign w_rx_ovf_evt = w_rx_wr && w_rx_full && !rx_rd;

  assign pndng    = !w_tx_empty;
  assign rx_valid = !w_rx_empty;
  assign rx_ovf   = r_rx_ovf;

  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr     (tx_wr),
    .i_wr_dat (tx_data),
    .i_rd     (pop),
    .o_rd_dat (D_pop),
    .o_full   (tx_full),
    .o_empty  (w_tx_empty),
    .o_count  (w_tx_count)
  );

  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr     (w_rx_wr),
    .i_wr_dat (D_push),
    .i_rd     (rx_rd),
    .o_rd_dat (rx_data),
    .o_full   (w_rx_full),
    .o_empty  (w_rx_empty),
    .o_count  (w_rx_count)
  );

  // Occupancy is not needed at this level; full/empty carry everything used here.
  logic w_unused_count;
  assign w_unused_count = &{1'b0, w_tx_count, w_rx_count};

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset)            r_rx_ovf <= 1'b0;
    else if (w_rx_ovf_evt) r_rx_ovf <= 1'b1;
  end

`ifdef BUS_DEV_STATS_EN
  logic        w_tx_pop;
  logic        w_rx_acc;
  logic        w_drop;
  logic [15:0] r_tx_cnt;
  logic [15:0] r_rx_cnt;
  logic [15:0] r_drop_cnt;

  assign w_tx_pop = pop && !w_tx_empty;
  assign w_rx_acc = w_rx_wr && !w_rx_ovf_evt;
  assign w_drop   = push && (!w_match || w_rx_ovf_evt);

  // Saturating event counters for packets popped, accepted and discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_tx_pop && r_tx_cnt   != 16'hFFFF) r_tx_cnt   <= r_tx_cnt   + 16'd1;
      if (w_rx_acc && r_rx_cnt   != 16'hFFFF) r_rx_cnt   <= r_rx_cnt   + 16'd1;
      if (w_drop   && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign tx_cnt   = r_tx_cnt;
  assign rx_cnt   = r_rx_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
